mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single 256-bit data-memory port between the instruction cache (port 0) and the data cache (port 1). Each cache drives a cache-side memory interface: enable held high until ack, write, address, 256-bit line. The arbiter grants one port at a time and holds the grant until the memory acknowledges. It forwards the granted port's request to memory, returns the ack only to that port, and holds the returned line for the cycle after ack. It sits between both cache tops and the data-memory model in the CPU top level.

## Interface
Parameters:
- None; line width is fixed at 256 bits and address width at 32 bits.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge
- rst_i  input  1  reset, asynchronous, active-low
- m0_enable_i / m1_enable_i  input  1  port request; held high until the port's ack
- m0_write_i / m1_write_i  input  1  1 = line write, 0 = line read
- m0_addr_i / m1_addr_i  input  32  line address, bits [4:0] = 0
- m0_data_i / m1_data_i  input  256  write line
- m0_ack_o / m1_ack_o  output  1  transaction complete for this port
- m0_data_o / m1_data_o  output  256  read line, broadcast to both ports
- mem_enable_o  output  1  memory request
- mem_write_o  output  1  memory write
- mem_addr_o  output  32  memory address
- mem_data_o  output  256  memory write line
- mem_data_i  input  256  memory read line
- mem_ack_i  input  1  memory acknowledge, 1 cycle

## Operation
- Registered state: state ∈ {IDLE, GRANT0, GRANT1, DONE}, last (index of the last served port, 1 bit), data_q (256 bits).
- IDLE: arbitrate among asserted m*_enable_i.
  - If port n wins, go to GRANTn at the next edge.
  - If no port requests, stay in IDLE.
- GRANTn:
  - mem_enable_o, mem_write_o, mem_addr_o and mem_data_o are combinational copies of port n's inputs.
  - mn_ack_o = mem_ack_i combinationally; the other port's ack is 0.
  - On mem_ack_i: capture data_q <= mem_data_i, set last <= n, go to DONE.
  - Without mem_ack_i: stay in GRANTn. The grant is never revoked, even if port n drops its enable; memory then sees mem_enable_o = 0.
- DONE:
  - Memory outputs are 0.
  - Arbitrate with port `last` masked, because a cache still holds enable high in its post-ack cycle.
  - If the other port requests, go directly to its GRANT state; otherwise go to IDLE.
- Memory outputs outside GRANT: mem_enable_o, mem_write_o, mem_addr_o and mem_data_o are all 0.
- mem_ack_i arriving in IDLE or DONE is ignored; no ack is forwarded and data_q is unchanged.
- m0_data_o = m1_data_o = (GRANT state and mem_ack_i) ? mem_data_i : data_q. The line is therefore valid in the ack cycle and stays stable until the next ack.
- Arbitration on a tie (both requesting in IDLE): resolved as described under Configuration.

## Timing
- Reset values (asynchronous, on rst_i low):
  - state = IDLE, last = 0, data_q = 0.
  - All ack outputs and all mem_* outputs = 0.
  - m*_data_o = 0.
- Reset mid-transaction: the grant is abandoned and the memory request drops in the same instant (combinational through state).
- Latency, from a request first seen in IDLE at cycle c:
  - mem_enable_o = 1 in cycle c+1.
  - Memory ack in cycle k gives mn_ack_o = 1 in cycle k, DONE in k+1.
  - The other port's grant is visible at k+2.
  - The same port's next request cannot be granted before k+3: k+1 is DONE (masked), k+2 is IDLE arbitration, k+3 is GRANT.
- Back-to-back same-port transactions (dcache writeback followed by refill, enable held high) therefore see a 2-cycle gap in mem_enable_o.
- A GRANT state lasts at least 1 cycle; an ack in the first granted cycle is legal.

## Configuration
- MEM_ARB_RR_EN defined: round-robin tie-break in IDLE. The port not equal to `last` wins, so port 1 wins the first tie after reset.
- MEM_ARB_RR_EN undefined: fixed priority in IDLE, port 1 (dcache) always wins ties.
- The DONE-state masking of port `last` applies in both builds.

## Test plan
- Single read: m0 read addr 0x0000_0400 at cycle 0, memory acks at cycle 5 with line 0xA5…A5.
  - Required: mem_enable_o 1 in cycles 1–5, mem_addr_o = 0x400.
  - Required: m0_ack_o = 1 only in cycle 5; m1_ack_o = 0 throughout.
  - Required: m0_data_o = 0xA5…A5 from cycle 5 until the next ack.
- Collision: both ports request in the same IDLE cycle.
  - Without MEM_ARB_RR_EN: port 1 is served first, then port 0 is granted at DONE.
  - With MEM_ARB_RR_EN: the first two collisions after reset serve port 1 then port 0, and the following collision starts with port 1 again.
- Writeback then refill: m1 writes addr 0x800 (ack at cycle 4) and holds enable for a read of 0xC00.
  - Required: mem_write_o = 1 in cycles 1–4, mem_enable_o = 0 in cycles 5–6.
  - Required: read grant visible at cycle 7 with mem_write_o = 0 and mem_addr_o = 0xC00.
- Stray ack: mem_ack_i pulsed in IDLE with data 0xFF…FF.
  - Required: no ack output asserted, m*_data_o unchanged, state stays IDLE.
- Reset mid-grant: rst_i pulled low during GRANT0 before any ack.
  - Required: mem_enable_o drops immediately and all outputs are 0.
  - Required: after release, a pending m0 request is re-granted from IDLE with 1-cycle latency.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the 256-bit data-memory port between icache (m0) and dcache (m1).
// Optional `MEM_ARB_RR_EN: round-robin tie-break in IDLE; otherwise dcache wins ties.
module mem_arbiter (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         m0_enable_i,
    input  logic         m0_write_i,
    input  logic [31:0]  m0_addr_i,
    input  logic [255:0] m0_data_i,
    output logic         m0_ack_o,
    output logic [255:0] m0_data_o,
    input  logic         m1_enable_i,
    input  logic         m1_write_i,
    input  logic [31:0]  m1_addr_i,
    input  logic [255:0] m1_data_i,
    output logic         m1_ack_o,
    output logic [255:0] m1_data_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT0,
        GRANT1,
        DONE
    } state_t;

    state_t       state_q, state_d;
    logic         last_q, last_d;
    logic [255:0] data_q, data_d;
    logic         g0, g1;
    logic         tie_win;

`ifdef MEM_ARB_RR_EN
    assign tie_win = ~last_q;
`else
    assign tie_win = 1'b1;
`endif

    assign g0 = (state_q == GRANT0);
    assign g1 = (state_q == GRANT1);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (m0_enable_i && m1_enable_i)
                    state_d = tie_win ? GRANT1 : GRANT0;
                else if (m1_enable_i)
                    state_d = GRANT1;
                else if (m0_enable_i)
                    state_d = GRANT0;
            end
            GRANT0: begin
                if (mem_ack_i) begin
                    data_d  = mem_data_i;
                    last_d  = 1'b0;
                    state_d = DONE;
                end
            end
            GRANT1: begin
                if (mem_ack_i) begin
                    data_d  = mem_data_i;
                    last_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // the port just served still holds enable this cycle
                if (last_q ? m0_enable_i : m1_enable_i)
                    state_d = last_q ? GRANT0 : GRANT1;
                else
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        unique case (1'b1)
            g0: begin
                mem_enable_o = m0_enable_i;
                mem_write_o  = m0_write_i;
                mem_addr_o   = m0_addr_i;
                mem_data_o   = m0_data_i;
            end
            g1: begin
                mem_enable_o = m1_enable_i;
                mem_write_o  = m1_write_i;
                mem_addr_o   = m1_addr_i;
                mem_data_o   = m1_data_i;
            end
            default: ;
        endcase
    end

    assign m0_ack_o  = g0 & mem_ack_i;
    assign m1_ack_o  = g1 & mem_ack_i;
    assign m0_data_o = ((g0 | g1) & mem_ack_i) ? mem_data_i : data_q;
    assign m1_data_o = m0_data_o;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with an ack-driven scoreboard for mem_arbiter.
module tb_mem_arbiter;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         m0_enable_i = 1'b0, m1_enable_i = 1'b0;
    logic         m0_write_i = 1'b0, m1_write_i = 1'b0;
    logic [31:0]  m0_addr_i = '0, m1_addr_i = '0;
    logic [255:0] m0_data_i = '0, m1_data_i = '0;
    logic         m0_ack_o, m1_ack_o;
    logic [255:0] m0_data_o, m1_data_o;
    logic         mem_enable_o, mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i = '0;
    logic         mem_ack_i = 1'b0;

    typedef struct {
        logic         port;
        logic [31:0]  addr;
        logic         wr;
        logic [255:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    localparam logic [255:0] LA5 = {32{8'hA5}};
    localparam logic [255:0] LFF = {256{1'b1}};
    localparam logic [255:0] WL  = {8{32'hDEAD_BEEF}};

    mem_arbiter dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .m0_enable_i  (m0_enable_i),
        .m0_write_i   (m0_write_i),
        .m0_addr_i    (m0_addr_i),
        .m0_data_i    (m0_data_i),
        .m0_ack_o     (m0_ack_o),
        .m0_data_o    (m0_data_o),
        .m1_enable_i  (m1_enable_i),
        .m1_write_i   (m1_write_i),
        .m1_addr_i    (m1_addr_i),
        .m1_data_i    (m1_data_i),
        .m1_ack_o     (m1_ack_o),
        .m1_data_o    (m1_data_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chkb(input string nm, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0b exp=%0b t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic chka(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic chkd(input string nm, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [255:0] line_of(input logic [31:0] a);
        return {8{a ^ 32'h5A5A_0000}};
    endfunction

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    task automatic set_port(input logic p, input logic en, input logic wr,
                            input logic [31:0] a, input logic [255:0] d);
        if (p) begin
            m1_enable_i = en; m1_write_i = wr; m1_addr_i = a; m1_data_i = d;
        end else begin
            m0_enable_i = en; m0_write_i = wr; m0_addr_i = a; m0_data_i = d;
        end
    endtask

    task automatic mem(input logic ack, input logic [255:0] d);
        mem_ack_i  = ack;
        mem_data_i = d;
    endtask

    task automatic expect_ack(input logic p, input logic [31:0] a,
                              input logic wr, input logic [255:0] d);
        exp_t e;
        e.port = p; e.addr = a; e.wr = wr; e.data = d;
        exp_q.push_back(e);
    endtask

    // scoreboard monitor: every forwarded ack must match the oldest expectation
    always @(negedge clk_i) begin
        if (rst_i && (m0_ack_o || m1_ack_o)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_ack got=%0b%0b exp=none t=%0t",
                         m1_ack_o, m0_ack_o, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chkb("sb_ack0", m0_ack_o, !e.port);
                chkb("sb_ack1", m1_ack_o, e.port);
                chka("sb_addr", mem_addr_o, e.addr);
                chkb("sb_write", mem_write_o, e.wr);
                chkd("sb_data0", m0_data_o, e.data);
                chkd("sb_data1", m1_data_o, e.data);
            end
        end
    end

    task automatic do_collision(input logic first);
        logic [31:0] af, ao;
        af = first ? 32'h200 : 32'h100;
        ao = first ? 32'h100 : 32'h200;
        nxt();
        set_port(1'b0, 1'b1, 1'b0, 32'h100, '0);
        set_port(1'b1, 1'b1, 1'b0, 32'h200, '0);
        mem(1'b0, '0);
        smp();
        chkb("col_idle_en", mem_enable_o, 1'b0);
        nxt();
        mem(1'b1, line_of(af));
        expect_ack(first, af, 1'b0, line_of(af));
        smp();
        chkb("col_first_en", mem_enable_o, 1'b1);
        chka("col_first_addr", mem_addr_o, af);
        nxt();
        mem(1'b0, '0);
        smp();
        chkb("col_done_en", mem_enable_o, 1'b0);
        nxt();
        set_port(first, 1'b0, 1'b0, '0, '0);
        mem(1'b1, line_of(ao));
        expect_ack(!first, ao, 1'b0, line_of(ao));
        smp();
        chkb("col_second_en", mem_enable_o, 1'b1);
        chka("col_second_addr", mem_addr_o, ao);
        nxt();
        mem(1'b0, '0);
        smp();
        chkb("col_done2_en", mem_enable_o, 1'b0);
        chkd("col_hold", m0_data_o, line_of(ao));
        nxt();
        set_port(!first, 1'b0, 1'b0, '0, '0);
        smp();
        chkb("col_end_en", mem_enable_o, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        // reset state, with a request and a stray ack present
        m0_enable_i = 1'b1;
        mem_ack_i   = 1'b1;
        #12;
        chkb("rst_en", mem_enable_o, 1'b0);
        chkb("rst_ack0", m0_ack_o, 1'b0);
        chkd("rst_data", m0_data_o, '0);
        chka("rst_addr", mem_addr_o, '0);
        m0_enable_i = 1'b0;
        mem_ack_i   = 1'b0;
        nxt();
        rst_i = 1'b1;

        // single read from m0, ack in cycle 5
        for (int c = 0; c < 8; c++) begin
            nxt();
            if (c == 0) set_port(1'b0, 1'b1, 1'b0, 32'h400, '0);
            if (c == 7) set_port(1'b0, 1'b0, 1'b0, '0, '0);
            if (c == 5) begin
                mem(1'b1, LA5);
                expect_ack(1'b0, 32'h400, 1'b0, LA5);
            end else begin
                mem(1'b0, {32{8'h33}});
            end
            smp();
            chkb("rd_en", mem_enable_o, (c >= 1 && c <= 5));
            if (c >= 1 && c <= 5) chka("rd_addr", mem_addr_o, 32'h400);
            chkb("rd_ack1", m1_ack_o, 1'b0);
            if (c != 5) chkb("rd_ack0", m0_ack_o, 1'b0);
            if (c >= 5) chkd("rd_data", m1_data_o, LA5);
        end

        // stray ack in IDLE
        nxt();
        mem(1'b1, LFF);
        smp();
        chkb("stray_ack0", m0_ack_o, 1'b0);
        chkb("stray_ack1", m1_ack_o, 1'b0);
        chkd("stray_data", m0_data_o, LA5);
        nxt();
        mem(1'b0, '0);
        smp();
        chkb("stray_idle_en", mem_enable_o, 1'b0);
        chkd("stray_dataq", m1_data_o, LA5);

        // collision after reset: dcache first in both builds
        do_collision(1'b1);

        // dcache writeback then refill with enable held
        for (int c = 0; c < 10; c++) begin
            nxt();
            if (c == 0) set_port(1'b1, 1'b1, 1'b1, 32'h800, WL);
            if (c == 5) set_port(1'b1, 1'b1, 1'b0, 32'hC00, '0);
            if (c == 9) set_port(1'b1, 1'b0, 1'b0, '0, '0);
            if (c == 4) begin
                mem(1'b1, '0);
                expect_ack(1'b1, 32'h800, 1'b1, '0);
            end else if (c == 7) begin
                mem(1'b1, line_of(32'hC00));
                expect_ack(1'b1, 32'hC00, 1'b0, line_of(32'hC00));
            end else begin
                mem(1'b0, '0);
            end
            smp();
            chkb("wb_en", mem_enable_o, (c >= 1 && c <= 4) || c == 7);
            if (c >= 1 && c <= 4) begin
                chkb("wb_write", mem_write_o, 1'b1);
                chkd("wb_wdata", mem_data_o, WL);
            end
            if (c == 7) begin
                chkb("rf_write", mem_write_o, 1'b0);
                chka("rf_addr", mem_addr_o, 32'hC00);
            end
        end

        // tie with last = dcache: build decides the winner
`ifdef MEM_ARB_RR_EN
        do_collision(1'b0);
`else
        do_collision(1'b1);
`endif

        // reset in the middle of a GRANT0
        nxt();
        set_port(1'b0, 1'b1, 1'b0, 32'h400, '0);
        smp();
        nxt();
        smp();
        chkb("mid_grant_en", mem_enable_o, 1'b1);
        #1;
        rst_i = 1'b0;
        mem(1'b1, LFF);
        #1;
        chkb("mid_rst_en", mem_enable_o, 1'b0);
        chkb("mid_rst_ack0", m0_ack_o, 1'b0);
        chka("mid_rst_addr", mem_addr_o, '0);
        chkd("mid_rst_data", m0_data_o, '0);
        chkb("mid_rst_write", mem_write_o, 1'b0);
        mem(1'b0, '0);
        nxt();
        rst_i = 1'b1;
        smp();
        chkb("post_rst_idle", mem_enable_o, 1'b0);
        nxt();
        mem(1'b1, line_of(32'h400));
        expect_ack(1'b0, 32'h400, 1'b0, line_of(32'h400));
        smp();
        chkb("post_rst_en", mem_enable_o, 1'b1);
        chka("post_rst_addr", mem_addr_o, 32'h400);
        nxt();
        mem(1'b0, '0);
        smp();
        nxt();
        set_port(1'b0, 1'b0, 1'b0, '0, '0);
        smp();
        repeat (2) nxt();
        chka("sb_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
